// File: rtl/typing_pkg.sv
// Shared types and ASCII constants for the typing trainer progress engine.
package typing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCheck,
    StDone
  } state_e;

  localparam logic [6:0] ASCII_NUL       = 7'h00;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_PRINT_MIN) && (c <= ASCII_PRINT_MAX);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Elapsed-seconds counter: prescaler divides clk by CLK_HZ, seconds saturate at 0xFFFF.
module sec_timer #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] seconds
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMax = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   sec_q, sec_d;

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (enable) begin
      if (presc_q == PMax) begin
        presc_d = '0;
        if (sec_q != 16'hFFFF) sec_d = sec_q + 16'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  assign seconds = sec_q;

endmodule

// File: rtl/typing_tracker.sv
// Keystroke checker for the typing trainer: compares keys against the prompt ROM,
// drives the renderer cursor and keeps error count, elapsed time and completion.
module typing_tracker
  import typing_pkg::*;
#(
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  output logic [11:0] prompt_index,
  input  logic [6:0]  prompt_char,
  output logic [31:0] correct_index_x,
  output logic [31:0] correct_index_y,
  output logic [15:0] error_count,
  output logic [15:0] elapsed_sec,
  output logic        done
);

  localparam int unsigned XW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW    = $clog2(ROWS + 1);
  localparam int unsigned IdxW  = 12;
  localparam int unsigned Total = COLS * ROWS;
  localparam logic [XW-1:0] XMax = XW'(COLS - 1);

  state_e          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [XW-1:0]   x_q, x_d, x_adv;
  logic [YW-1:0]   y_q, y_d, y_adv;
  logic [15:0]     err_q, err_d;
  logic [IdxW-1:0] idx_q, idx_d, lin_adv;
  logic            key_take;
  logic            match;
  logic            timer_en;

  assign key_ready = (state_q == StIdle) || (state_q == StRun);
  assign key_take  = key_valid && key_ready && is_printable(key_ascii);
  assign match     = !key_q[7] && (key_q[6:0] == prompt_char);
  assign timer_en  = (state_q == StRun) || (state_q == StCheck);

  always_comb begin
    x_adv = x_q + XW'(1);
    y_adv = y_q;
    if (x_q == XMax) begin
      x_adv = '0;
      y_adv = y_q + YW'(1);
    end
    lin_adv = IdxW'(y_adv) * IdxW'(COLS) + IdxW'(x_adv);
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (key_take) begin
          key_d   = key_ascii;
          state_d = StCheck;
        end
      end
      StRun: begin
        // Terminator check wins over a key arriving in the same cycle.
        if (prompt_char == ASCII_NUL) begin
          state_d = StDone;
        end else if (key_take) begin
          key_d   = key_ascii;
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StRun;
        if (match) begin
          x_d = x_adv;
          y_d = y_adv;
          if (lin_adv == IdxW'(Total)) state_d = StDone;
        end else if (err_q != 16'hFFFF) begin
          err_d = err_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    idx_d = IdxW'(y_d) * IdxW'(COLS) + IdxW'(x_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state_q <= StIdle;
      key_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  sec_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (restart),
    .enable  (timer_en),
    .seconds (elapsed_sec)
  );

  assign prompt_index    = idx_q;
  assign correct_index_x = 32'(x_q);
  assign correct_index_y = 32'(y_q);
  assign error_count     = err_q;
  assign done            = (state_q == StDone);

endmodule

// File: tb/tb_typing_tracker.sv
// Bench for typing_tracker: directed scenarios plus random prompts, checked against a
// linear-position model of typing progress.
module tb_typing_tracker;

  localparam int unsigned COLS   = 64;
  localparam int unsigned ROWS   = 5;
  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned TOTAL  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        key_ready;
  logic [11:0] prompt_index;
  logic [6:0]  prompt_char;
  logic [31:0] correct_index_x;
  logic [31:0] correct_index_y;
  logic [15:0] error_count;
  logic [15:0] elapsed_sec;
  logic        done;

  logic [6:0] rom [0:4095];
  assign prompt_char = rom[prompt_index];

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // Model: progress is a single linear position into the prompt.
  int m_pos, m_err, m_start, m_done_edge;
  bit m_started, m_done;

  typing_tracker #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .restart         (restart),
    .key_valid       (key_valid),
    .key_ascii       (key_ascii),
    .key_ready       (key_ready),
    .prompt_index    (prompt_index),
    .prompt_char     (prompt_char),
    .correct_index_x (correct_index_x),
    .correct_index_y (correct_index_y),
    .error_count     (error_count),
    .elapsed_sec     (elapsed_sec),
    .done            (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit done_now();
    return m_done && (cycle >= m_done_edge);
  endfunction

  function automatic int exp_elapsed();
    int e;
    if (!m_started) return 0;
    e = (m_done && m_done_edge < cycle) ? m_done_edge : cycle;
    e = (e - m_start) / CLK_HZ;
    return (e > 65535) ? 65535 : e;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/x"},     correct_index_x, 32'(m_pos % COLS));
    chk({tag, "/y"},     correct_index_y, 32'(m_pos / COLS));
    chk({tag, "/idx"},   32'(prompt_index), 32'(m_pos));
    chk({tag, "/err"},   32'(error_count), 32'(m_err));
    chk({tag, "/done"},  32'(done), 32'(done_now()));
    chk({tag, "/ready"}, 32'(key_ready), 32'(!done_now()));
    chk({tag, "/sec"},   32'(elapsed_sec), 32'(exp_elapsed()));
  endtask

  task automatic model_reset();
    m_pos = 0; m_err = 0; m_start = 0; m_done_edge = 0;
    m_started = 0; m_done = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 7'h7F;
  endtask

  task automatic model_key(input logic [7:0] c, input int ek);
    if (!m_done && c >= 8'h20 && c <= 8'h7E) begin
      if (!m_started) begin
        m_started = 1;
        m_start   = ek;
      end
      if (c[6:0] == rom[m_pos]) m_pos++;
      else if (m_err < 65535) m_err++;
      if (m_pos == TOTAL) begin
        m_done = 1; m_done_edge = ek + 1;
      end else if (rom[m_pos] == 7'h00) begin
        m_done = 1; m_done_edge = ek + 2;
      end
    end
  endtask

  task automatic send_key(input logic [7:0] c, input string tag);
    int ek;
    @(negedge clk);
    key_valid = 1'b1;
    key_ascii = c;
    ek = cycle + 1;
    model_key(c, ek);
    @(negedge clk);
    key_valid = 1'b0;
    key_ascii = 8'h00;
    @(negedge clk);
    check_all({tag, "+1"});
    @(negedge clk);
    check_all({tag, "+2"});
  endtask

  task automatic do_restart(input bit with_key, input logic [7:0] c);
    @(negedge clk);
    restart   = 1'b1;
    key_valid = with_key;
    key_ascii = c;
    @(negedge clk);
    restart   = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    model_reset();
  endtask

  initial begin
    int ek;
    int len;
    logic [7:0] c;
    clear_rom();
    model_reset();

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // "Hi" then NUL
    rom[0] = 7'h48; rom[1] = 7'h69; rom[2] = 7'h00;
    send_key(8'h48, "hi_H");
    send_key(8'h69, "hi_i");
    repeat (30) @(negedge clk);
    check_all("hi_frozen");

    // "a": wrong key, CR, right key, CR after done
    do_restart(1'b0, 8'h00);
    clear_rom();
    rom[0] = 7'h61; rom[1] = 7'h00;
    send_key(8'h62, "a_wrong");
    send_key(8'h0D, "a_cr");
    send_key(8'h61, "a_right");
    send_key(8'h0D, "a_cr_done");

    // Full prompt, no terminator
    do_restart(1'b0, 8'h00);
    check_all("restart");
    clear_rom();
    for (int i = 0; i < TOTAL; i++) rom[i] = 7'($urandom_range(32'h20, 32'h7E));
    for (int i = 0; i < TOTAL; i++) send_key({1'b0, rom[i]}, "full");
    repeat (25) @(negedge clk);
    check_all("full_frozen");

    // Back-to-back key_valid: second key lands in the check cycle and is dropped
    do_restart(1'b0, 8'h00);
    clear_rom();
    rom[0] = 7'h61; rom[1] = 7'h61; rom[2] = 7'h00;
    @(negedge clk);
    key_valid = 1'b1;
    key_ascii = 8'h61;
    ek = cycle + 1;
    model_key(8'h61, ek);
    @(negedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key_ascii = 8'h00;
    check_all("dbl+1");
    @(negedge clk);
    check_all("dbl+2");
    repeat (35) @(negedge clk);
    check_all("timer35");

    // Restart beats a simultaneous key mid-prompt
    do_restart(1'b1, 8'h61);
    check_all("rst_key");
    repeat (15) @(negedge clk);
    check_all("rst_idle");

    // Random prompts with mostly-correct typing and arbitrary wrong bytes
    for (int r = 0; r < 3; r++) begin
      do_restart(1'b0, 8'h00);
      clear_rom();
      len = int'($urandom_range(5, 40));
      for (int i = 0; i < len; i++) rom[i] = 7'($urandom_range(32'h20, 32'h7E));
      rom[len] = 7'h00;
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 3) != 0) c = {1'b0, rom[m_pos]};
        else c = 8'($urandom_range(0, 255));
        send_key(c, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
